// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the iterative multiply/divide unit.
//   - op code constants (MULT/MULTU/DIV/DIVU/MTHI/MTLO and, with
//     MD_ACCUM_EN defined, MADD/MADDU/MSUB/MSUBU)
//   - FSM state enum (IDLE, MUL, DIV, FIX)
//   - helper constants/functions for the all-ones and most-negative values
//   - op classification helpers
// Optional feature macro: MD_ACCUM_EN (multiply-accumulate op codes).
package md_pkg;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MADD  = 4'b1000;
    localparam logic [3:0] OP_MADDU = 4'b1001;
    localparam logic [3:0] OP_MSUB  = 4'b1010;
    localparam logic [3:0] OP_MSUBU = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } md_state_t;

    localparam int MAX_WIDTH = 64;

    // Slice [WIDTH-1:0] of these to get the per-instance constants.
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

    function automatic logic [MAX_WIDTH-1:0] min_value(input int width);
        return 64'd1 << (width - 1);
    endfunction

    // Multiply class: plain multiplies, plus the accumulate forms when built in.
    function automatic logic is_mul(input logic [3:0] op);
`ifdef MD_ACCUM_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op[3:2] == 2'b10);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Every arithmetic code with bit 0 clear is the signed variant.
    function automatic logic is_signed(input logic [3:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/md_div_step.sv
// md_div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit (MSB of quo) into the partial remainder,
// trial-subtracts the divisor and shifts the resulting quotient bit into
// the LSB of quo.
// Ports:
//   rem      in  WIDTH  partial remainder
//   quo      in  WIDTH  remaining dividend bits / quotient being built
//   divisor  in  WIDTH  divisor magnitude
//   rem_next out WIDTH  partial remainder after this step
//   quo_next out WIDTH  quotient register after this step
module md_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        // A borrow out of the top bit means the trial subtraction failed.
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/md_unit_iter.sv
// md_unit_iter: iterative multiply/divide unit with HI/LO registers.
// Multiply retires MUL_BITS multiplier bits per cycle (WIDTH/MUL_BITS
// cycles), divide is restoring, one bit per cycle (WIDTH cycles); a final
// FIX cycle applies signs and commits HI/LO. Abort returns to IDLE at the
// next edge without touching HI/LO.
// Optional feature macro: MD_ACCUM_EN enables MADD/MADDU/MSUB/MSUBU.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   request strobe, accepted only in IDLE
//   op        in   4-bit op code (see md_pkg)
//   a, b      in   rs / rt operands
//   abort     in   flush; cancels an in-flight operation
//   busy      out  operation in flight
//   done      out  one-cycle pulse after HI/LO commit
//   div_zero  out  sticky: last divide had b==0
//   hi, lo    out  architectural HI/LO
//   fsm_state out  current FSM state (md_state_t encoding)
module md_unit_iter
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       fsm_state
);
    localparam int               N_MUL = WIDTH / MUL_BITS;
    localparam int               N_DIV = WIDTH;
    localparam int               SW    = WIDTH + MUL_BITS;
    localparam logic [WIDTH-1:0] ONES  = ALL_ONES[WIDTH-1:0];

    md_state_t        state, state_next;
    logic [6:0]       cnt;
    logic [3:0]       op_q;
    logic             neg_a, neg_b;
    // Working registers, shared by both datapaths:
    //   multiply: rem = running high half, quo = multiplier / low half, dvs = |a|
    //   divide:   rem = partial remainder, quo = dividend / quotient, dvs = |b|
    logic [WIDTH-1:0] rem, quo, dvs;

    logic             accept, launch, sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [SW-1:0]    mul_sum;
    logic [WIDTH-1:0] div_rem, div_quo;
    logic [2*WIDTH-1:0] prod_mag, prod_signed, mul_commit;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    assign accept = (state == S_IDLE) && start && !abort;
    assign launch = accept && (is_mul(op) || is_div(op));
    assign sgn_a  = is_signed(op) && a[WIDTH-1];
    assign sgn_b  = is_signed(op) && b[WIDTH-1];
    assign mag_a  = sgn_a ? -a : a;
    assign mag_b  = sgn_b ? -b : b;

    // Radix-2^MUL_BITS shift-add: add |a| * digit into the high half, then
    // shift the 2*WIDTH pair right by MUL_BITS.
    assign mul_sum = SW'(rem) + SW'(dvs) * SW'(quo[MUL_BITS-1:0]);

    md_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (div_rem),
        .quo_next (div_quo)
    );

    // Sign correction / commit values used in FIX.
    always_comb begin
        prod_mag    = {rem, quo};
        prod_signed = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
        mul_commit  = prod_signed;
`ifdef MD_ACCUM_EN
        if (op_q[3]) begin
            mul_commit = op_q[1] ? ({hi, lo} - prod_signed) : ({hi, lo} + prod_signed);
        end
`endif
        quo_fix = (neg_a ^ neg_b) ? -quo : quo;
        // Divide by zero: the remainder path already yields a; force lo.
        if (dvs == '0) begin
            quo_fix = ONES;
        end
        rem_fix = neg_a ? -rem : rem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && is_mul(op)) begin
                        state_next = S_MUL;
                    end else if (start && is_div(op)) begin
                        state_next = S_DIV;
                    end
                end
                S_MUL:   if (cnt == '0) state_next = S_FIX;
                S_DIV:   if (cnt == '0) state_next = S_FIX;
                S_FIX:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            op_q     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (accept && (is_mul(op) || is_div(op) || op == OP_MTHI || op == OP_MTLO)) begin
                div_zero <= 1'b0;
            end
            if (accept && op == OP_MTHI) hi <= a;
            if (accept && op == OP_MTLO) lo <= a;

            if (launch) begin
                op_q  <= op;
                neg_a <= sgn_a;
                neg_b <= sgn_b;
                rem   <= '0;
                if (is_mul(op)) begin
                    cnt <= 7'(N_MUL - 1);
                    dvs <= mag_a;
                    quo <= mag_b;
                end else begin
                    cnt <= 7'(N_DIV - 1);
                    dvs <= mag_b;
                    quo <= mag_a;
                end
            end else if (!abort) begin
                case (state)
                    S_MUL: begin
                        rem <= mul_sum[SW-1:MUL_BITS];
                        quo <= {mul_sum[MUL_BITS-1:0], quo[WIDTH-1:MUL_BITS]};
                        cnt <= cnt - 7'd1;
                    end
                    S_DIV: begin
                        rem <= div_rem;
                        quo <= div_quo;
                        cnt <= cnt - 7'd1;
                    end
                    S_FIX: begin
                        done <= 1'b1;
                        if (is_div(op_q)) begin
                            hi       <= rem_fix;
                            lo       <= quo_fix;
                            div_zero <= (dvs == '0);
                        end else begin
                            {hi, lo} <= mul_commit;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_md_unit_iter.sv
// tb_md_unit_iter: self-checking bench for md_unit_iter (WIDTH=32,
// MUL_BITS=2). Expected {hi,lo} values come from a behavioural model and
// are queued at launch, then popped when the done pulse appears.
// Honours MD_ACCUM_EN the same way as the design.
module tb_md_unit_iter;
    localparam int W      = 32;
    localparam int LAT_M  = 17;
    localparam int LAT_D  = 33;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic [1:0]   fsm_state;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] model_acc = '0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    md_unit_iter #(.WIDTH(W), .MUL_BITS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo),
        .fsm_state (fsm_state)
    );

    function automatic logic [63:0] md_model(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc);
        longint sp;
        logic [63:0] up;
        int xi, yi, qi, ri;
        logic [31:0] qv, rv;
        sp = longint'($signed(x)) * longint'($signed(y));
        up = {32'd0, x} * {32'd0, y};
        case (o)
            4'b0000: return sp;
            4'b0001: return up;
            4'b0010: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                xi = x; yi = y; qi = xi / yi; ri = xi % yi;
                qv = qi; rv = ri;
                return {rv, qv};
            end
            4'b0011: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            4'b1000: return acc + sp;
            4'b1001: return acc + up;
            4'b1010: return acc - sp;
            4'b1011: return acc - up;
            default: return acc;
        endcase
    endfunction

    // Launch one multi-cycle op, check latency, done pulse, result and flag.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int exp_busy, input logic exp_dz, input string name);
        logic [63:0] e;
        logic [63:0] got;
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        e = md_model(o, x, y, model_acc);
        exp_q.push_back(e);
        model_acc = e;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        tests++;
        if (div_zero !== 1'b0) begin
            fails++; $display("FAIL %s dz_clear: got %b expected 0", name, div_zero);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        tests++;
        if (cyc !== exp_busy) begin
            fails++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, exp_busy);
        end
        tests++;
        if (done !== 1'b1) begin
            fails++; $display("FAIL %s done: got %b expected 1", name, done);
        end
        got = {hi, lo};
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        tests++;
        if (got !== e) begin
            fails++; $display("FAIL %s hilo: got %h expected %h", name, got, e);
        end
        tests++;
        if (div_zero !== exp_dz) begin
            fails++; $display("FAIL %s div_zero: got %b expected %b", name, div_zero, exp_dz);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL %s done_width: got %b expected 0", name, done);
        end
    endtask

    task automatic write_hilo(input logic [3:0] o, input logic [31:0] x);
        @(negedge clk);
        start = 1'b1; op = o; a = x;
        @(negedge clk);
        start = 1'b0;
        if (o == 4'b0100) model_acc[63:32] = x; else model_acc[31:0] = x;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== model_acc) begin
            fails++;
            $display("FAIL mt_write: got busy=%b done=%b hilo=%h expected busy=0 done=0 hilo=%h",
                     busy, done, {hi, lo}, model_acc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, div_zero} !== 3'b000 || {hi, lo} !== 64'd0 || fsm_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hilo=%h st=%0d expected all 0",
                     busy, done, div_zero, {hi, lo}, fsm_state);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
            fails++; $display("FAIL reset_release: got busy=%b hilo=%h expected 0", busy, {hi, lo});
        end
    endtask

    task automatic test_mult();
        run_op(4'b0000, 32'hFFFFFFFD, 32'd7, LAT_M, 1'b0, "mult_neg");
    endtask

    task automatic test_div();
        run_op(4'b0010, 32'hFFFFFFF9, 32'd2, LAT_D, 1'b0, "div_neg");
        run_op(4'b0010, 32'd100, 32'hFFFFFFF9, LAT_D, 1'b0, "div_negdivisor");
    endtask

    task automatic test_div_zero();
        run_op(4'b0011, 32'h10, 32'd0, LAT_D, 1'b1, "divu_zero");
        run_op(4'b0001, 32'd3, 32'd5, LAT_M, 1'b0, "multu_clear");
    endtask

    task automatic test_abort();
        logic saw_done;
        write_hilo(4'b0101, 32'h1234);
        @(negedge clk);
        start = 1'b1; op = 4'b0001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || lo !== 32'h1234 || hi !== model_acc[63:32]) begin
            fails++;
            $display("FAIL abort_state: got busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=00001234",
                     busy, hi, lo, model_acc[63:32]);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        tests++;
        if (saw_done !== 1'b0 || lo !== 32'h1234) begin
            fails++; $display("FAIL abort_nodone: got done_seen=%b lo=%h expected 0 and 00001234", saw_done, lo);
        end
        run_op(4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_M, 1'b0, "multu_rerun");
        tests++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            fails++; $display("FAIL multu_const: got %h expected fffffffe00000001", {hi, lo});
        end
    endtask

    task automatic test_div_overflow();
        run_op(4'b0010, 32'h80000000, 32'hFFFFFFFF, LAT_D, 1'b0, "div_overflow");
    endtask

    task automatic test_accum();
`ifdef MD_ACCUM_EN
        write_hilo(4'b0100, 32'd0);
        write_hilo(4'b0101, 32'd0);
        run_op(4'b1001, 32'd5, 32'd6, LAT_M, 1'b0, "maddu");
        run_op(4'b1010, 32'd2, 32'd3, LAT_M, 1'b0, "msub");
        tests++;
        if ({hi, lo} !== 64'd24) begin
            fails++; $display("FAIL accum_const: got %h expected 24", {hi, lo});
        end
`else
        @(negedge clk);
        start = 1'b1; op = 4'b1000; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || fsm_state !== 2'd0 || {hi, lo} !== model_acc) begin
            fails++;
            $display("FAIL noop_1000: got busy=%b st=%0d hilo=%h expected busy=0 st=0 hilo=%h",
                     busy, fsm_state, {hi, lo}, model_acc);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL noop_done: got %b expected 0", done);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [3:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 8; i++) begin
            o = 4'($urandom_range(0, 3));
            x = $urandom;
            y = (i == 5) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op(o, x, y, o[1] ? LAT_D : LAT_M, o[1] && (y == 32'd0), "random_op");
        end
    endtask

    task automatic test_reset_mid_div();
        run_op(4'b0011, 32'h55, 32'd0, LAT_D, 1'b1, "pre_reset_divu");
        @(negedge clk);
        start = 1'b1; op = 4'b0010; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({busy, done, div_zero} !== 3'b000 || {hi, lo} !== 64'd0) begin
            fails++;
            $display("FAIL reset_async: got busy=%b done=%b dz=%b hilo=%h expected all 0",
                     busy, done, div_zero, {hi, lo});
        end
        exp_q.delete();
        model_acc = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || fsm_state !== 2'd0) begin
            fails++; $display("FAIL reset_idle: got busy=%b st=%0d expected 0", busy, fsm_state);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_abort();
        test_div_overflow();
        test_accum();
        test_back_to_back();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
